instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Fetch stage of the RISC-V single-cycle core.
- Owns the program counter (PC) and issues requests to an instruction memory that answers with variable latency.
- Presents one fetched instruction (`Instr`, `PC`, `PCPlus4`) to decode and the main/ALU controllers, then computes the next PC when that instruction retires, using the ALU controller's `PCSrc`, `ImmExt` and `ALUResult`.
- Keeps a retired-instruction counter.

## Interface

Clock is `clk`. Reset is `rst`: asynchronous, active-high.

Parameters:
- `XLEN`, 32 — address and data width.
- `RESET_PC`, 32'h0000_0000 — PC value loaded at reset.

Ports:
- `clk` — in, 1 — core clock. All state changes on the rising edge.
- `rst` — in, 1 — asynchronous, active-high reset.
- `imem_req` — out, 1 — fetch request. Held high until `imem_ready`.
- `imem_addr` — out, XLEN — fetch address, equal to the current PC.
- `imem_ready` — in, 1 — memory response valid this cycle. Ignored when `imem_req` is 0.
- `imem_rdata` — in, 32 — instruction word, sampled when `imem_req && imem_ready`.
- `instr_valid` — out, 1 — `Instr`/`PC`/`PCPlus4` hold a fetched instruction.
- `instr_ready` — in, 1 — execute retires the presented instruction this cycle.
- `Instr` — out, 32 — instruction register.
- `PC` — out, XLEN — address of `Instr`.
- `PCPlus4` — out, XLEN — `PC + 4`, mod 2^XLEN.
- `PCSrc` — in, 2 — next-PC select. Sampled only at retire.
- `ImmExt` — in, XLEN — sign-extended immediate for the branch/jal target.
- `ALUResult` — in, XLEN — jalr target.
- `instret` — out, 32 — count of retired instructions.
- `fetch_fault` — out, 1 — misaligned-target fault. Exists only under the macro.

## Operation

State machine with states FETCH, HOLD and FAULT (FAULT only under the macro).

- **FETCH**
  - Outputs: `imem_req`=1, `imem_addr`=PC, `instr_valid`=0.
  - On `imem_ready`: load `Instr`←`imem_rdata`, go to HOLD.
  - Otherwise stay in FETCH with the address held stable.
- **HOLD**
  - Outputs: `instr_valid`=1, `imem_req`=0. `Instr` and `PC` are stable.
  - On `instr_ready` (retire):
    - PC ← next_pc.
    - `instret` ← `instret`+1, wrapping at 2^32.
    - Go to FETCH, or to FAULT (see Configuration).
- **next_pc** selection:
  - `PCSrc`=00 → `PC+4`.
  - `PCSrc`=01 → `PC+ImmExt`.
  - `PCSrc`=10 → `{ALUResult[XLEN-1:1],1'b0}`.
  - `PCSrc`=11 → `PC+4` (reserved).
- **Arithmetic**: all additions are XLEN-bit, modulo 2^XLEN, with no overflow flag. `PC`=32'hFFFF_FFFC retiring with `PCSrc`=00 gives next PC 0.
- **Combinational paths**:
  - `PCSrc`, `ImmExt` and `ALUResult` are combinational functions of `Instr`. They are sampled only in the retire cycle.
  - The block has no combinational path from `instr_ready` to `imem_req`.
- **Reset values**, while `rst` is high and immediately after:
  - state=FETCH, `PC`=RESET_PC, `Instr`=32'h0000_0013 (nop), `instret`=0, `fetch_fault`=0.
  - `imem_req` is forced to 0 while `rst`=1 and asserts in the first cycle with `rst`=0.
- **Reset mid-operation**:
  - An outstanding memory request is abandoned. A late `imem_ready` is ignored unless it coincides with the new request.
  - The state and registers return to the reset values asynchronously.

## Timing

- **Fetch latency**: `instr_valid` rises on the edge after the cycle in which `imem_req && imem_ready` (minimum 1 cycle).
- **Retire-to-request**: `imem_req` for the next PC asserts in the cycle after retire.
- **Throughput**: the best case is one instruction per 2 cycles, with `imem_ready` tied to 1 and `instr_ready` tied to 1.
- **Back-pressure**: `instr_ready`=0 in HOLD stalls indefinitely with all outputs stable.
- **Out-of-state inputs**: `instr_ready` in FETCH and `imem_ready` in HOLD are ignored.
- **`instret`** updates on the same edge as PC.

## Configuration

Macro: `FETCH_MISALIGN_TRAP_EN`.

- **Defined**:
  - A retire whose next_pc has bits [1:0]≠00 still updates PC and `instret`, then enters FAULT.
  - In FAULT: `fetch_fault`=1, `imem_req`=0, `instr_valid`=0.
  - FAULT is sticky until `rst`.
- **Undefined**:
  - No FAULT state and no `fetch_fault` port.
  - next_pc bits [1:0] are forced to 00 before loading.

## Test plan

1. **Reset and first fetch**: release reset with RESET_PC=32'h100 and `imem_ready`=1. Required:
   - `imem_addr`=32'h100 in cycle 1.
   - `instr_valid`=1 in cycle 2 with `PC`=32'h100 and `PCPlus4`=32'h104.
   - `instret`=0.
2. **Memory wait states**: hold `imem_ready`=0 for 3 cycles. Required:
   - `imem_req` and `imem_addr` stay stable.
   - `instr_valid` rises only after the `imem_ready` cycle.
3. **Branch and jump redirect**:
   - At `PC`=32'h200, retire with `PCSrc`=01 and `ImmExt`=32'hFFFF_FFF0 → next `imem_addr`=32'h1F0.
   - Retire with `PCSrc`=10 and `ALUResult`=32'h305 → next `imem_addr`=32'h304.
4. **Decode back-pressure**: `instr_ready`=0 for 5 cycles in HOLD. Required:
   - `Instr`, `PC` and `instret` unchanged.
   - `imem_req`=0.
   - A single retire increments `instret` by exactly 1.
5. **Wrap and reset mid-fetch**:
   - `PC`=32'hFFFF_FFFC retired with `PCSrc`=00 → next `imem_addr`=0.
   - Preload `instret` to 32'hFFFF_FFFF, then retire → `instret`=0.
   - Assert `rst` while `imem_req`=1 → `PC`=RESET_PC and `instr_valid`=0 immediately.
6. **Misalignment under `FETCH_MISALIGN_TRAP_EN`**: retire with `PCSrc`=01 to target 32'h202. Required:
   - `fetch_fault`=1 and `imem_req`=0 next cycle, sticky until `rst`.
   - Without the macro, the next `imem_addr`=32'h200.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the single-cycle RISC-V core; owns the PC and the retired-instruction counter.
// Latency: instr_valid rises on the edge after imem_req && imem_ready; the next request follows one cycle after retire.
// Backpressure: instr_ready=0 in HOLD stalls with all outputs stable; memory wait states hold imem_req/imem_addr stable.
//
// Ports:
//   clk, rst                  - core clock; asynchronous active-high reset
//   imem_req/imem_addr        - instruction memory request and address (address == PC)
//   imem_ready/imem_rdata     - memory response valid and instruction word
//   instr_valid/instr_ready   - presented-instruction handshake towards decode/execute
//   Instr, PC, PCPlus4        - presented instruction, its address and address + 4
//   PCSrc, ImmExt, ALUResult  - next-PC controls from the ALU controller, sampled at retire
//   instret                   - retired-instruction counter (wraps at 2^32)
//   fetch_fault               - misaligned-target fault, present only with FETCH_MISALIGN_TRAP_EN
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a retire to a target with bits [1:0] != 00 loads the PC, counts the retire and
//               enters a sticky FAULT state that only rst leaves.
//   undefined - no FAULT state and no fetch_fault port; targets are forced word aligned.

module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,

    // instruction memory side
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,

    // decode / execute side
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,

    // next-PC controls, combinational functions of Instr
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult,

    output logic [31:0]     instret
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [31:0]     INSTR_NOP   = 32'h0000_0013; // addi x0, x0, 0
    localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MASK   = ~XLEN'(1);     // clears bit 0 of the jalr target
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);     // clears bits [1:0] of any target

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_HOLD  = 2'b01,
        S_FAULT = 2'b10
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_HOLD  = 2'b01
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       instret_q, instret_d;

    // ------------------------------------------------------------------
    // Next-PC datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   pc_branch;
    logic [XLEN-1:0]   pc_jalr;
    logic [XLEN-1:0]   next_pc_raw;
    logic [XLEN-1:0]   next_pc_load;
    logic              next_pc_misaligned;
    logic              retire;

    // All additions are modulo 2^XLEN; carries out are intentionally dropped.
    assign pc_plus4  = pc_q + PC_STEP;
    assign pc_branch = pc_q + ImmExt;
    assign pc_jalr   = ALUResult & JALR_MASK;

    always_comb begin
        next_pc_raw = pc_plus4;
        case (PCSrc)
            PCSRC_SEQ:    next_pc_raw = pc_plus4;
            PCSRC_BRANCH: next_pc_raw = pc_branch;
            PCSRC_JALR:   next_pc_raw = pc_jalr;
            default:      next_pc_raw = pc_plus4;   // reserved encoding behaves as sequential
        endcase
    end

    assign next_pc_misaligned = (next_pc_raw[1:0] != 2'b00);

`ifdef FETCH_MISALIGN_TRAP_EN
    // The faulting target is still loaded so software/debug can see where it went.
    assign next_pc_load = next_pc_raw;
`else
    // Without the trap the low bits are simply dropped.
    assign next_pc_load = next_pc_raw & ALIGN_MASK;
`endif

    // A retire only exists while an instruction is being presented.
    assign retire = (state_q == S_HOLD) && instr_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;

        case (state_q)
            S_FETCH: begin
                // imem_ready is only meaningful while the request is up; in
                // this state the request is up whenever rst is low, and rst
                // holds the registers in reset regardless.
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (retire) begin
                    pc_d      = next_pc_load;
                    instret_d = instret_q + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_d   = next_pc_misaligned ? S_FAULT : S_FETCH;
`else
                    state_d   = S_FETCH;
`endif
                end
            end

`ifdef FETCH_MISALIGN_TRAP_EN
            S_FAULT: begin
                // Sticky: nothing but rst leaves this state.
                state_d = S_FAULT;
            end
`endif

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= INSTR_NOP;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // imem_req depends only on registered state and rst, so there is no
    // combinational path from instr_ready back to the memory request.
    // Gating with rst abandons any outstanding request during reset.
    assign imem_req    = (state_q == S_FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign instret     = instret_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state_q == S_FAULT);
`else
    // Misalignment is absorbed by the alignment mask in this build.
    logic unused_misaligned;
    assign unused_misaligned = next_pc_misaligned;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic            clk;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     Instr;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic [1:0]      PCSrc;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] ALUResult;
    logic [31:0]     instret;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_fault;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .ALUResult   (ALUResult),
        .instret     (instret)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complete a fetch that is currently being requested, with one ready cycle.
    task automatic fetch(input logic [31:0] word);
        imem_rdata = word;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
    endtask

    // Retire the presented instruction with the given next-PC controls.
    task automatic retire(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
        PCSrc       = src;
        ImmExt      = imm;
        ALUResult   = alu;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 2'b00;
    endtask

    initial begin
        rst         = 1'b1;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 2'b00;
        ImmExt      = 32'h0;
        ALUResult   = 32'h0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_imem_req",    {31'b0, imem_req},    32'h0);
        check("rst_pc",          PC,                   32'h0000_0100);
        check("rst_instr_nop",   Instr,                32'h0000_0013);
        check("rst_instret",     instret,              32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_fault",       {31'b0, fetch_fault}, 32'h0);
`endif

        // ---------------- 1: first fetch ----------------
        rst = 1'b0;
        #1;
        check("c1_imem_req",     {31'b0, imem_req},    32'h1);
        check("c1_imem_addr",    imem_addr,            32'h0000_0100);
        check("c1_instr_valid",  {31'b0, instr_valid}, 32'h0);
        fetch(32'h0050_0093);
        check("c2_instr_valid",  {31'b0, instr_valid}, 32'h1);
        check("c2_pc",           PC,                   32'h0000_0100);
        check("c2_pcplus4",      PCPlus4,              32'h0000_0104);
        check("c2_instr",        Instr,                32'h0050_0093);
        check("c2_instret",      instret,              32'h0);
        check("c2_imem_req",     {31'b0, imem_req},    32'h0);

        // ---------------- 4: decode back-pressure (imem_ready in HOLD ignored) ----------------
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_imem_req", {31'b0, imem_req},    32'h0);
            check("bp_valid",    {31'b0, instr_valid}, 32'h1);
        end
        imem_ready = 1'b0;
        check("bp_instr",   Instr,   32'h0050_0093);
        check("bp_pc",      PC,      32'h0000_0100);
        check("bp_instret", instret, 32'h0);
        retire(2'b00, 32'h0, 32'h0);
        check("ret1_instret",  instret,              32'h1);
        check("ret1_imem_req", {31'b0, imem_req},    32'h1);
        check("ret1_addr",     imem_addr,            32'h0000_0104);
        check("ret1_valid",    {31'b0, instr_valid}, 32'h0);

        // ---------------- 2: memory wait states (instr_ready in FETCH ignored) ----------------
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_imem_req", {31'b0, imem_req},    32'h1);
            check("ws_addr",     imem_addr,            32'h0000_0104);
            check("ws_valid",    {31'b0, instr_valid}, 32'h0);
        end
        instr_ready = 1'b0;
        check("ws_instret", instret, 32'h1);
        fetch(32'h0000_0063);
        check("ws_valid_after", {31'b0, instr_valid}, 32'h1);
        check("ws_instr",       Instr,                32'h0000_0063);

        // ---------------- 3: branch / jump redirect ----------------
        retire(2'b01, 32'h0000_00FC, 32'h0);          // 0x104 + 0xFC = 0x200
        check("br_to_200", imem_addr, 32'h0000_0200);
        fetch(32'h0000_0063);
        retire(2'b01, 32'hFFFF_FFF0, 32'h0);          // 0x200 - 16 = 0x1F0
        check("br_back_addr", imem_addr, 32'h0000_01F0);
        check("br_instret",   instret,   32'h3);
        fetch(32'h0000_0067);
        retire(2'b10, 32'h0000_0040, 32'h0000_0305);  // jalr clears bit 0
        check("jalr_addr", imem_addr, 32'h0000_0304);
        fetch(32'h0000_0013);
        retire(2'b11, 32'h0000_0040, 32'h0000_0500);  // reserved -> PC+4
        check("rsvd_addr", imem_addr, 32'h0000_0308);

        // ---------------- 5: PC wrap and instret wrap ----------------
        fetch(32'h0000_0067);
        retire(2'b10, 32'h0, 32'hFFFF_FFFC);
        check("jalr_top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        check("top_pc",      PC,      32'hFFFF_FFFC);
        check("top_pcplus4", PCPlus4, 32'h0000_0000);
        retire(2'b00, 32'h0, 32'h0);
        check("wrap_addr",    imem_addr, 32'h0000_0000);
        check("wrap_instret", instret,   32'h7);
        fetch(32'h0000_0063);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("preload_instret", instret, 32'hFFFF_FFFF);
        retire(2'b01, 32'h0000_0200, 32'h0);
        check("instret_wrap", instret,   32'h0);
        check("post_wrap_pc", imem_addr, 32'h0000_0200);

        // ---------------- 6: misaligned target 0x202 ----------------
        fetch(32'h0000_0063);
        retire(2'b01, 32'h0000_0002, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_fault",    {31'b0, fetch_fault}, 32'h1);
        check("mis_imem_req", {31'b0, imem_req},    32'h0);
        check("mis_valid",    {31'b0, instr_valid}, 32'h0);
        check("mis_pc",       PC,                   32'h0000_0202);
        check("mis_instret",  instret,              32'h1);
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mis_sticky", {31'b0, fetch_fault}, 32'h1);
            check("mis_noreq",  {31'b0, imem_req},    32'h0);
        end
        imem_ready  = 1'b0;
        instr_ready = 1'b0;
`else
        check("mis_aligned_addr", imem_addr,         32'h0000_0200);
        check("mis_imem_req",     {31'b0, imem_req}, 32'h1);
        check("mis_instret",      instret,           32'h1);
        // Stay in a wait state so a request is outstanding when reset hits.
        tick();
        check("pre_rst_req", {31'b0, imem_req}, 32'h1);
`endif

        // ---------------- 5: reset mid-fetch, late ready ignored ----------------
        #2;
        rst        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        #1;
        check("mrst_pc",      PC,                   32'h0000_0100);
        check("mrst_valid",   {31'b0, instr_valid}, 32'h0);
        check("mrst_req",     {31'b0, imem_req},    32'h0);
        check("mrst_instret", instret,              32'h0);
        check("mrst_instr",   Instr,                32'h0000_0013);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mrst_fault",   {31'b0, fetch_fault}, 32'h0);
`endif
        tick();
        check("mrst_hold_valid", {31'b0, instr_valid}, 32'h0);
        check("mrst_hold_instr", Instr,                32'h0000_0013);
        rst        = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h0010_0113;
        #1;
        check("rel_req",  {31'b0, imem_req}, 32'h1);
        check("rel_addr", imem_addr,         32'h0000_0100);

        // ---------------- throughput: ready tied high -> one instruction per 2 cycles ----------------
        instr_ready = 1'b1;
        tick();
        check("tp_valid_a", {31'b0, instr_valid}, 32'h1);
        check("tp_instr",   Instr,                32'h0010_0113);
        tick();
        check("tp_valid_b", {31'b0, instr_valid}, 32'h0);
        check("tp_addr_b",  imem_addr,            32'h0000_0104);
        tick();
        check("tp_valid_c", {31'b0, instr_valid}, 32'h1);
        tick();
        check("tp_addr_d",  imem_addr,            32'h0000_0108);
        check("tp_instret", instret,              32'h2);
        instr_ready = 1'b0;
        imem_ready  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of the test");
        $fatal(1, "timeout");
    end

endmodule
